exe_mem_stage: RTL

//   Elastic EXE->MEM pipeline stage with valid/ready handshake, parametrised widths,

---
 rtl/exe_mem_stage.sv | 137 +++++++++++++
 1 files changed

// File: rtl/exe_mem_stage.sv
// Elastic EXE->MEM pipeline stage with valid/ready handshake, flush and forwarding tap.
// Optional SKID_EN macro adds a 1-entry skid register so in_ready comes from a flop.
module exe_mem_stage #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_regWr,
  input  logic              in_memWr,
  input  logic              in_memRd,
  input  logic [DATA_W-1:0] in_aluRes,
  input  logic [DATA_W-1:0] in_memWrData,
  input  logic [REG_AW-1:0] in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_regWr,
  output logic              out_memWr,
  output logic              out_memRd,
  output logic [DATA_W-1:0] out_aluRes,
  output logic [DATA_W-1:0] out_memWrData,
  output logic [REG_AW-1:0] out_rd,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_data
);

  localparam int unsigned CTL_LSB = 2 * DATA_W + REG_AW;
  localparam int unsigned OP_W    = CTL_LSB + 3;

  logic [OP_W-1:0] in_op;
  logic [OP_W-1:0] m_op;
  logic [OP_W-1:0] m_op_d;
  logic            m_valid;
  logic            m_valid_d;
  logic            accept;
  logic            retire;

  assign in_op  = {in_regWr, in_memWr, in_memRd, in_aluRes, in_memWrData, in_rd};
  assign accept = in_valid & in_ready;
  assign retire = m_valid & out_ready;

`ifdef SKID_EN
  logic [OP_W-1:0] s_op;
  logic [OP_W-1:0] s_op_d;
  logic            s_valid;
  logic            s_valid_d;

  assign in_ready = ~s_valid;

  // Next-state for main and skid entries; control bits cleared whenever M empties
  always_comb begin
    m_valid_d = m_valid;
    m_op_d    = m_op;
    s_valid_d = s_valid;
    s_op_d    = s_op;
    if (flush) begin
      m_valid_d                  = 1'b0;
      s_valid_d                  = 1'b0;
      m_op_d[OP_W-1:CTL_LSB]     = 3'b000;
    end else if (!m_valid) begin
      if (accept) begin
        m_valid_d = 1'b1;
        m_op_d    = in_op;
      end
    end else if (retire) begin
      if (s_valid) begin
        m_op_d    = s_op;
        s_valid_d = 1'b0;
      end else if (accept) begin
        m_op_d = in_op;
      end else begin
        m_valid_d              = 1'b0;
        m_op_d[OP_W-1:CTL_LSB] = 3'b000;
      end
    end else if (accept) begin
      s_valid_d = 1'b1;
      s_op_d    = in_op;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_valid <= 1'b0;
      s_op    <= '0;
    end else begin
      s_valid <= s_valid_d;
      s_op    <= s_op_d;
    end
  end
`else
  assign in_ready = ~m_valid | out_ready;

  // Single-entry next-state; in_ready guarantees accept only when empty or retiring
  always_comb begin
    m_valid_d = m_valid;
    m_op_d    = m_op;
    if (flush) begin
      m_valid_d              = 1'b0;
      m_op_d[OP_W-1:CTL_LSB] = 3'b000;
    end else if (accept) begin
      m_valid_d = 1'b1;
      m_op_d    = in_op;
    end else if (retire) begin
      m_valid_d              = 1'b0;
      m_op_d[OP_W-1:CTL_LSB] = 3'b000;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_op    <= '0;
    end else begin
      m_valid <= m_valid_d;
      m_op    <= m_op_d;
    end
  end

  assign out_valid     = m_valid;
  assign out_regWr     = m_op[CTL_LSB+2];
  assign out_memWr     = m_op[CTL_LSB+1];
  assign out_memRd     = m_op[CTL_LSB];
  assign out_aluRes    = m_op[CTL_LSB-1 -: DATA_W];
  assign out_memWrData = m_op[REG_AW +: DATA_W];
  assign out_rd        = m_op[REG_AW-1:0];

  // Control bits are zero while empty, so regWr alone qualifies the forwarding tap
  assign fwd_valid = m_op[CTL_LSB+2];
  assign fwd_rd    = m_op[REG_AW-1:0];
  assign fwd_data  = m_op[CTL_LSB-1 -: DATA_W];

endmodule
